// File: rtl/uart_wb_master_if.sv
// UART byte stream and classic Wishbone master signals bundled for the uart_wb_master bridge.
// The master modport is the bridge side; the slave modport is the UART cores / interconnect side.
interface uart_wb_master_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
) ();
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i, wb_err_i,
    output tx_data, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_dat_i, wb_ack_i, wb_err_i,
    input  tx_data, tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/uart_wb_master.sv
// UART-to-Wishbone master: assembles command frames from RX bytes, runs one classic Wishbone
// cycle with ack/err/timeout handling and returns a status byte plus read data over TX.
module uart_wb_master #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  uart_wb_master_if.master bus_if,
  output logic             busy,
  output logic             rx_overrun
);
  localparam int unsigned AB       = AW / 8;
  localparam int unsigned DB       = DW / 8;
  localparam logic [1:0]  AddrLast = 2'(AB - 1);
  localparam logic [1:0]  DataLast = 2'(DB - 1);
  localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StAddr     = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StWb       = 3'd3;
  localparam logic [2:0] StRespSt   = 3'd4;
  localparam logic [2:0] StRespData = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          tx_done;

  assign tx_done = tx_valid_q && bus_if.tx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rdat_d     = rdat_q;
    status_d   = status_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (bus_if.rx_valid) begin
          overrun_d = 1'b0;
          unique case (bus_if.rx_data[1:0])
            2'd0: begin
            end
            2'd1, 2'd2: begin
              state_d = StAddr;
              we_d    = (bus_if.rx_data[1:0] == 2'd1);
              cnt_d   = 2'd0;
            end
            default: begin
              state_d    = StRespSt;
              status_d   = 8'h03;
              tx_data_d  = 8'h03;
              tx_valid_d = 1'b1;
            end
          endcase
        end
      end
      StAddr: begin
        if (bus_if.rx_valid) begin
          adr_d = (adr_q << 8) | AW'(bus_if.rx_data);
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == AddrLast) begin
            cnt_d = 2'd0;
            if (we_q) begin
              state_d = StData;
            end else begin
              state_d = StWb;
              cyc_d   = 1'b1;
              tmo_d   = 16'd0;
            end
          end
        end
      end
      StData: begin
        if (bus_if.rx_valid) begin
          dat_d = (dat_q << 8) | DW'(bus_if.rx_data);
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == DataLast) begin
            cnt_d   = 2'd0;
            state_d = StWb;
            cyc_d   = 1'b1;
            tmo_d   = 16'd0;
          end
        end
      end
      StWb: begin
        tmo_d = tmo_q + 16'd1;
        // err takes priority over a simultaneous ack
        if (bus_if.wb_err_i) begin
          status_d = 8'h01;
        end else if (bus_if.wb_ack_i) begin
          status_d = 8'h00;
          if (!we_q) rdat_d = bus_if.wb_dat_i;
        end else if (tmo_q == TmoLast) begin
          status_d = 8'h02;
        end
        if (bus_if.wb_err_i || bus_if.wb_ack_i || (tmo_q == TmoLast)) begin
          state_d    = StRespSt;
          cyc_d      = 1'b0;
          tx_valid_d = 1'b1;
          tx_data_d  = status_d;
        end
      end
      StRespSt: begin
        if (tx_done) begin
          if (!we_q && (status_q == 8'h00)) begin
            state_d   = StRespData;
            cnt_d     = 2'd0;
            tx_data_d = rdat_q[DW-1 -: 8];
            rdat_d    = rdat_q << 8;
          end else begin
            state_d    = StIdle;
            tx_valid_d = 1'b0;
          end
        end
      end
      StRespData: begin
        if (tx_done) begin
          if (cnt_q == DataLast) begin
            state_d    = StIdle;
            tx_valid_d = 1'b0;
          end else begin
            cnt_d     = cnt_q + 2'd1;
            tx_data_d = rdat_q[DW-1 -: 8];
            rdat_d    = rdat_q << 8;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        cyc_d      = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase

    if (bus_if.rx_valid &&
        ((state_q == StWb) || (state_q == StRespSt) || (state_q == StRespData))) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      tmo_q      <= 16'd0;
      adr_q      <= '0;
      dat_q      <= '0;
      rdat_q     <= '0;
      status_q   <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rdat_q     <= rdat_d;
      status_q   <= status_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus_if.tx_data  = tx_data_q;
  assign bus_if.tx_valid = tx_valid_q;
  assign bus_if.wb_cyc_o = cyc_q;
  assign bus_if.wb_stb_o = cyc_q;
  assign bus_if.wb_we_o  = we_q;
  assign bus_if.wb_adr_o = adr_q;
  assign bus_if.wb_dat_o = dat_q;
  assign bus_if.wb_sel_o = {DB{cyc_q}};
  assign busy            = busy_q;
  assign rx_overrun      = overrun_q;
endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: table of complete frames plus overrun, NOP and reset sequences.
module tb_uart_wb_master;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] adr;
    logic [31:0] wdat;
    int          mode;     // 0 ack, 1 err, 2 ack+err, 3 silent
    int          ws;
    logic [31:0] rdata;
    logic        toggle;
    int          exp_cyc;
    int          exp_ntx;
    logic [39:0] exp_tx;   // first byte in the top octet
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, rx_overrun;

  uart_wb_master_if #(.AW(AW), .DW(DW)) bus_if ();

  uart_wb_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_if    (bus_if),
    .busy      (busy),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          s_mode = 0;
  int          s_ws = 0;
  logic [31:0] s_rdata = '0;
  logic        s_toggle = 1'b0;
  logic        rdy_tgl = 1'b0;
  int          cyc_cnt = 0;
  logic        cap_we;
  logic [15:0] cap_adr;
  logic [31:0] cap_dat;
  logic [3:0]  cap_sel;
  logic [7:0]  txq[$];
  int          hold_err = 0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        hit;
  vec_t        vecs[7];

  assign bus_if.wb_dat_i = s_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Slave, TX sink and hold monitor, all acting on the falling edge.
  always @(negedge clk) begin
    rdy_tgl = ~rdy_tgl;
    bus_if.tx_ready = s_toggle ? rdy_tgl : 1'b1;
    if (!rst) begin
      prev_stall = 1'b0;
      bus_if.wb_ack_i = 1'b0;
      bus_if.wb_err_i = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_cnt++;
        if (!bus_if.tx_valid || bus_if.tx_data !== prev_data) hold_err++;
      end
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_data  = bus_if.tx_data;
      if (bus_if.tx_valid && bus_if.tx_ready) txq.push_back(bus_if.tx_data);
      if (bus_if.wb_cyc_o) begin
        if (cyc_cnt == 0) begin
          cap_we  = bus_if.wb_we_o;
          cap_adr = bus_if.wb_adr_o;
          cap_dat = bus_if.wb_dat_o;
          cap_sel = bus_if.wb_sel_o;
        end
        hit = (cyc_cnt == s_ws);
        bus_if.wb_ack_i = hit && (s_mode == 0 || s_mode == 2);
        bus_if.wb_err_i = hit && (s_mode == 1 || s_mode == 2);
        cyc_cnt++;
      end else begin
        bus_if.wb_ack_i = 1'b0;
        bus_if.wb_err_i = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(v.cmd);
    if (v.cmd[1:0] != 2'd3) begin
      send_byte(v.adr[15:8]);
      send_byte(v.adr[7:0]);
      if (v.cmd[1:0] == 2'd1) for (int i = 3; i >= 0; i--) send_byte(v.wdat[8*i +: 8]);
    end
  endtask

  task automatic setup(input vec_t v);
    @(posedge clk);
    #1;
    s_mode    = v.mode;
    s_ws      = v.ws;
    s_rdata   = v.rdata;
    s_toggle  = v.toggle;
    cyc_cnt   = 0;
    hold_err  = 0;
    stall_cnt = 0;
    txq.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || bus_if.tx_valid) && n < 300);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_tx(input string tag, input int ntx, input logic [39:0] exp_tx);
    check({tag, " tx count"}, 32'(txq.size()), 32'(ntx));
    for (int i = 0; i < ntx; i++) begin
      check($sformatf("%s tx byte %0d", tag, i),
            (i < txq.size()) ? {24'h0, txq[i]} : 32'hFFFF_FFFF, {24'h0, exp_tx[39-8*i -: 8]});
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    setup(v);
    send_frame(v);
    wait_idle(tag);
    check({tag, " cyc cycles"}, 32'(cyc_cnt), 32'(v.exp_cyc));
    if (v.exp_cyc > 0) begin
      check({tag, " we"}, {31'h0, cap_we}, {31'h0, v.cmd[1:0] == 2'd1});
      check({tag, " adr"}, {16'h0, cap_adr}, {16'h0, v.adr});
      check({tag, " sel"}, {28'h0, cap_sel}, 32'hF);
      if (v.cmd[1:0] == 2'd1) check({tag, " dat_o"}, cap_dat, v.wdat);
    end
    check_tx(tag, v.exp_ntx, v.exp_tx);
    if (v.toggle) begin
      check({tag, " tx hold"}, 32'(hold_err), 32'd0);
      check({tag, " stalls seen"}, 32'(stall_cnt > 0), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t w;
    int   bmax;
    vecs[0] = '{8'h01, 16'h1234, 32'hDEADBEEF, 0, 2, 32'h0,        1'b0, 3, 1, 40'h00_0000_0000};
    vecs[1] = '{8'h02, 16'h0040, 32'h0,        0, 0, 32'hCAFEF00D, 1'b1, 1, 5, 40'h00_CAFE_F00D};
    vecs[2] = '{8'h02, 16'h0100, 32'h0,        2, 1, 32'h12345678, 1'b0, 2, 1, 40'h01_0000_0000};
    vecs[3] = '{8'h01, 16'h0200, 32'h0BADF00D, 3, 0, 32'h0,        1'b0, 8, 1, 40'h02_0000_0000};
    vecs[4] = '{8'h03, 16'h0000, 32'h0,        0, 0, 32'h0,        1'b0, 0, 1, 40'h03_0000_0000};
    vecs[5] = '{8'h01, 16'hFFFF, 32'h0,        1, 0, 32'h0,        1'b0, 1, 1, 40'h01_0000_0000};
    vecs[6] = '{8'hFE, 16'hA5A5, 32'h0,        0, 3, 32'h01020304, 1'b1, 4, 5, 40'h00_0102_0304};

    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst cyc", {31'h0, bus_if.wb_cyc_o}, 32'd0);
    check("rst stb", {31'h0, bus_if.wb_stb_o}, 32'd0);
    check("rst we", {31'h0, bus_if.wb_we_o}, 32'd0);
    check("rst adr", {16'h0, bus_if.wb_adr_o}, 32'd0);
    check("rst dat_o", bus_if.wb_dat_o, 32'd0);
    check("rst sel", {28'h0, bus_if.wb_sel_o}, 32'd0);
    check("rst tx_valid", {31'h0, bus_if.tx_valid}, 32'd0);
    check("rst tx_data", {24'h0, bus_if.tx_data}, 32'd0);
    check("rst busy", {31'h0, busy}, 32'd0);
    check("rst overrun", {31'h0, rx_overrun}, 32'd0);
    #2 rst = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Byte arriving during the Wishbone cycle sets the sticky overrun flag.
    w = '{8'h01, 16'h0010, 32'h11223344, 3, 0, 32'h0, 1'b0, 8, 1, 40'h02_0000_0000};
    setup(w);
    send_frame(w);
    send_byte(8'h55);
    check("overrun set", {31'h0, rx_overrun}, 32'd1);
    wait_idle("overrun");
    check("overrun cyc cycles", 32'(cyc_cnt), 32'(TMO));
    check_tx("overrun", 1, 40'h02_0000_0000);
    check("overrun sticky", {31'h0, rx_overrun}, 32'd1);

    // NOP clears overrun, stays idle, returns nothing.
    txq.delete();
    send_byte(8'h00);
    check("nop clears overrun", {31'h0, rx_overrun}, 32'd0);
    bmax = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) bmax = 1;
    end
    check("nop busy", 32'(bmax), 32'd0);
    check("nop tx count", 32'(txq.size()), 32'd0);

    // Reset while the cycle is outstanding.
    w = '{8'h01, 16'h0020, 32'hA5A55A5A, 3, 0, 32'h0, 1'b0, 0, 0, 40'h0};
    setup(w);
    send_frame(w);
    @(negedge clk);
    check("pre-reset cyc", {31'h0, bus_if.wb_cyc_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid-reset cyc", {31'h0, bus_if.wb_cyc_o}, 32'd0);
    check("mid-reset stb", {31'h0, bus_if.wb_stb_o}, 32'd0);
    check("mid-reset tx_valid", {31'h0, bus_if.tx_valid}, 32'd0);
    check("mid-reset busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    run_vec(vecs[1], "post-reset read");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
